// File: rtl/prog_mem_if.sv
// Fetch, unlock-key and programming signals of the program memory, bundled
// so the fetching master and the memory share one port.
interface prog_mem_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 11
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_err;
    logic              key_strobe;
    logic [7:0]        key_data;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_wdata;
    logic              prog_exit;
    logic              prog_mode;

    modport master (
        output fetch_req, fetch_addr, key_strobe, key_data,
               prog_we, prog_addr, prog_wdata, prog_exit,
        input  fetch_valid, fetch_data, fetch_err, prog_mode
    );

    modport slave (
        input  fetch_req, fetch_addr, key_strobe, key_data,
               prog_we, prog_addr, prog_wdata, prog_exit,
        output fetch_valid, fetch_data, fetch_err, prog_mode
    );
endinterface

// File: rtl/prog_mem.sv
// Program memory with a registered 1-cycle fetch port and a key-unlocked
// programming mode (55h then AAh on consecutive cycles) that blocks fetches.
module prog_mem #(
    parameter int              DATA_W   = 14,
    parameter int              ADDR_W   = 11,
    parameter int              DEPTH    = 2048,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    prog_mem_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {RUN = 2'd0, KEY1 = 2'd1, PROG = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              fetch_acc, wr_en;
    logic              fetch_in_range, prog_in_range;
    logic [IDX_W-1:0]  rd_idx, wr_idx;

    // Storage powers up as NOP_WORD and is never touched by reset.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

    // Full-width compare: no aliasing of out-of-range addresses.
    assign fetch_in_range = {1'b0, bus.fetch_addr} < DEPTH_L;
    assign prog_in_range  = {1'b0, bus.prog_addr} < DEPTH_L;
    assign rd_idx         = bus.fetch_addr[IDX_W-1:0];
    assign wr_idx         = bus.prog_addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.key_strobe && bus.key_data == 8'h55) state_d = KEY1;
            KEY1:    state_d = (bus.key_strobe && bus.key_data == 8'hAA) ? PROG : RUN;
            PROG:    if (bus.prog_exit) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        bus.prog_mode = (state_q == PROG);
        fetch_acc     = bus.fetch_req && (state_q != PROG);
        wr_en         = (state_q == PROG) && bus.prog_we && prog_in_range;
    end

    always_comb begin
        fetch_valid_d = fetch_acc;
        fetch_err_d   = fetch_acc && !fetch_in_range;
        fetch_data_d  = fetch_data_q;
        if (fetch_acc) begin
            fetch_data_d = fetch_in_range ? mem_q[rd_idx] : NOP_WORD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_data_q  <= NOP_WORD;
        end else begin
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
            fetch_data_q  <= fetch_data_d;
        end
    end

    // Fetch and write never coincide: fetches are blocked while in PROG.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= bus.prog_wdata;
        end
    end

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_err   = fetch_err_q;
    assign bus.fetch_data  = fetch_data_q;
endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: a default instance and a DEPTH=1000 instance with a
// non-zero NOP word share one stimulus stream and one behavioural model.
module tb_prog_mem;
    localparam int          DW      = 14;
    localparam int          AW      = 11;
    localparam int          DEPTH_A = 2048;
    localparam int          DEPTH_B = 1000;
    localparam logic [13:0] NOP_A   = 14'h0000;
    localparam logic [13:0] NOP_B   = 14'h2DAD;

    typedef struct packed {
        logic        req;
        logic [10:0] addr;
        logic        ks;
        logic [7:0]  kd;
        logic        we;
        logic [10:0] pa;
        logic [13:0] pd;
        logic        ex;
    } stim_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    prog_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    prog_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    assign bus_b.fetch_req  = bus_a.fetch_req;
    assign bus_b.fetch_addr = bus_a.fetch_addr;
    assign bus_b.key_strobe = bus_a.key_strobe;
    assign bus_b.key_data   = bus_a.key_data;
    assign bus_b.prog_we    = bus_a.prog_we;
    assign bus_b.prog_addr  = bus_a.prog_addr;
    assign bus_b.prog_wdata = bus_a.prog_wdata;
    assign bus_b.prog_exit  = bus_a.prog_exit;

    prog_mem dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    prog_mem #(.DEPTH(DEPTH_B), .NOP_WORD(NOP_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Reference model: 0 = RUN, 1 = first key byte seen, 2 = programming.
    logic [13:0] mem_a [DEPTH_A];
    logic [13:0] mem_b [DEPTH_B];
    int          mode;
    logic        exp_valid, exp_mode, exp_err_a, exp_err_b;
    logic [13:0] exp_data_a, exp_data_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [16:0] got_a();
        return {bus_a.fetch_valid, bus_a.fetch_err, bus_a.prog_mode, bus_a.fetch_data};
    endfunction
    function automatic logic [16:0] got_b();
        return {bus_b.fetch_valid, bus_b.fetch_err, bus_b.prog_mode, bus_b.fetch_data};
    endfunction
    function automatic logic [16:0] want_a();
        return {exp_valid, exp_err_a, exp_mode, exp_data_a};
    endfunction
    function automatic logic [16:0] want_b();
        return {exp_valid, exp_err_b, exp_mode, exp_data_b};
    endfunction

    function automatic stim_t s_idle();
        return '0;
    endfunction
    function automatic stim_t s_fetch(input logic [10:0] a);
        stim_t s = '0;
        s.req = 1'b1; s.addr = a;
        return s;
    endfunction
    function automatic stim_t s_key(input logic [7:0] k);
        stim_t s = '0;
        s.ks = 1'b1; s.kd = k;
        return s;
    endfunction
    function automatic stim_t s_wr(input logic [10:0] a, input logic [13:0] d, input logic ex);
        stim_t s = '0;
        s.we = 1'b1; s.pa = a; s.pd = d; s.ex = ex;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus_a.fetch_req  = s.req;
        bus_a.fetch_addr = s.addr;
        bus_a.key_strobe = s.ks;
        bus_a.key_data   = s.kd;
        bus_a.prog_we    = s.we;
        bus_a.prog_addr  = s.pa;
        bus_a.prog_wdata = s.pd;
        bus_a.prog_exit  = s.ex;
    endtask

    task automatic model_reset();
        mode       = 0;
        exp_valid  = 1'b0;
        exp_mode   = 1'b0;
        exp_err_a  = 1'b0;
        exp_err_b  = 1'b0;
        exp_data_a = NOP_A;
        exp_data_b = NOP_B;
    endtask

    // Advance the model by one clock using the currently applied inputs, then
    // clock the DUTs and settle 1 time unit past the edge.
    task automatic tick();
        int  a, p;
        logic acc;
        a   = int'(bus_a.fetch_addr);
        p   = int'(bus_a.prog_addr);
        acc = bus_a.fetch_req && (mode != 2);
        exp_valid = acc;
        exp_err_a = acc && (a >= DEPTH_A);
        exp_err_b = acc && (a >= DEPTH_B);
        if (acc) begin
            exp_data_a = (a < DEPTH_A) ? mem_a[a] : NOP_A;
            exp_data_b = (a < DEPTH_B) ? mem_b[a] : NOP_B;
        end
        if (mode == 2 && bus_a.prog_we) begin
            if (p < DEPTH_A) mem_a[p] = bus_a.prog_wdata;
            if (p < DEPTH_B) mem_b[p] = bus_a.prog_wdata;
        end
        if (mode == 0)      mode = (bus_a.key_strobe && bus_a.key_data == 8'h55) ? 1 : 0;
        else if (mode == 1) mode = (bus_a.key_strobe && bus_a.key_data == 8'hAA) ? 2 : 0;
        else                mode = bus_a.prog_exit ? 0 : 2;
        exp_mode = (mode == 2);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(s_fetch(11'd3));
        #2 rst_n = 1'b0;
        #1 model_reset();
        n_cmp++;
        if (got_a() !== want_a()) begin n_bad++; $display("FAIL reset_async_a: got %h expected %h", got_a(), want_a()); end
        n_cmp++;
        if (got_b() !== want_b()) begin n_bad++; $display("FAIL reset_async_b: got %h expected %h", got_b(), want_b()); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (got_a() !== want_a()) begin n_bad++; $display("FAIL reset_edge_a: got %h expected %h", got_a(), want_a()); end
        n_cmp++;
        if (got_b() !== want_b()) begin n_bad++; $display("FAIL reset_edge_b: got %h expected %h", got_b(), want_b()); end
        rst_n = 1'b1;
        apply(s_idle());
    endtask

    task automatic test_default_fetch();
        stim_t seq[$];
        for (int i = 0; i < 8; i++) seq.push_back(s_fetch(11'(i)));
        seq.push_back(s_idle());
        seq.push_back(s_fetch(11'h7FF));
        foreach (seq[i]) begin
            apply(seq[i]);
            tick();
            n_cmp++;
            if (got_a() !== want_a()) begin n_bad++; $display("FAIL default_fetch_a[%0d]: got %h expected %h", i, got_a(), want_a()); end
            n_cmp++;
            if (got_b() !== want_b()) begin n_bad++; $display("FAIL default_fetch_b[%0d]: got %h expected %h", i, got_b(), want_b()); end
        end
    endtask

    task automatic test_program();
        stim_t seq[$];
        seq = '{s_key(8'h55), s_key(8'hAA), s_wr(11'h000, 14'h3044, 1'b0),
                s_wr(11'h007, 14'h3E07, 1'b0), s_idle(), s_key(8'h55),
                s_wr(11'h008, 14'h0808, 1'b1), s_fetch(11'h007), s_fetch(11'h000),
                s_fetch(11'h008)};
        foreach (seq[i]) begin
            apply(seq[i]);
            tick();
            n_cmp++;
            if (got_a() !== want_a()) begin n_bad++; $display("FAIL program_a[%0d]: got %h expected %h", i, got_a(), want_a()); end
            n_cmp++;
            if (got_b() !== want_b()) begin n_bad++; $display("FAIL program_b[%0d]: got %h expected %h", i, got_b(), want_b()); end
        end
    endtask

    task automatic test_bad_key();
        stim_t seq[$];
        seq = '{s_key(8'h55), s_idle(), s_key(8'hAA), s_wr(11'h010, 14'h1234, 1'b0),
                s_key(8'h55), s_wr(11'h010, 14'h1234, 1'b0), s_key(8'h55), s_key(8'h55),
                s_key(8'hAA), s_fetch(11'h010)};
        foreach (seq[i]) begin
            apply(seq[i]);
            tick();
            n_cmp++;
            if (got_a() !== want_a()) begin n_bad++; $display("FAIL bad_key_a[%0d]: got %h expected %h", i, got_a(), want_a()); end
            n_cmp++;
            if (got_b() !== want_b()) begin n_bad++; $display("FAIL bad_key_b[%0d]: got %h expected %h", i, got_b(), want_b()); end
        end
    endtask

    task automatic test_out_of_range();
        stim_t seq[$];
        seq = '{s_fetch(11'h3E8), s_fetch(11'h3E7), s_key(8'h55), s_key(8'hAA),
                s_wr(11'h3E7, 14'h1111, 1'b0), s_wr(11'h3E8, 14'h2222, 1'b0),
                s_wr(11'h7FF, 14'h0F0F, 1'b1), s_fetch(11'h3E7), s_fetch(11'h3E8),
                s_fetch(11'h7FF), s_fetch(11'h3E6), s_idle()};
        foreach (seq[i]) begin
            apply(seq[i]);
            tick();
            n_cmp++;
            if (got_a() !== want_a()) begin n_bad++; $display("FAIL out_of_range_a[%0d]: got %h expected %h", i, got_a(), want_a()); end
            n_cmp++;
            if (got_b() !== want_b()) begin n_bad++; $display("FAIL out_of_range_b[%0d]: got %h expected %h", i, got_b(), want_b()); end
        end
    endtask

    task automatic test_prog_fetch_block();
        stim_t seq[$];
        stim_t both;
        both = s_wr(11'h005, 14'h2ABC, 1'b1);
        both.req = 1'b1; both.addr = 11'h005;
        seq = '{s_key(8'h55), s_key(8'hAA), s_fetch(11'h005), s_fetch(11'h3E8), both,
                s_fetch(11'h005), s_fetch(11'h005)};
        foreach (seq[i]) begin
            apply(seq[i]);
            tick();
            n_cmp++;
            if (got_a() !== want_a()) begin n_bad++; $display("FAIL prog_block_a[%0d]: got %h expected %h", i, got_a(), want_a()); end
            n_cmp++;
            if (got_b() !== want_b()) begin n_bad++; $display("FAIL prog_block_b[%0d]: got %h expected %h", i, got_b(), want_b()); end
        end
    endtask

    task automatic test_reset_in_prog();
        stim_t seq[$];
        apply(s_fetch(11'h007));
        tick();
        apply(s_idle());
        #2 rst_n = 1'b0;
        #1 model_reset();
        n_cmp++;
        if (got_a() !== want_a()) begin n_bad++; $display("FAIL reset_run_a: got %h expected %h", got_a(), want_a()); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply(s_key(8'h55)); tick();
        apply(s_key(8'hAA)); tick();
        apply(s_wr(11'h020, 14'h1357, 1'b0)); tick();
        n_cmp++;
        if (got_a() !== want_a()) begin n_bad++; $display("FAIL reset_prog_entry_a: got %h expected %h", got_a(), want_a()); end
        apply(s_wr(11'h000, 14'h0BAD, 1'b0));
        #2 rst_n = 1'b0;
        #1 model_reset();
        n_cmp++;
        if (got_a() !== want_a()) begin n_bad++; $display("FAIL reset_prog_a: got %h expected %h", got_a(), want_a()); end
        n_cmp++;
        if (got_b() !== want_b()) begin n_bad++; $display("FAIL reset_prog_b: got %h expected %h", got_b(), want_b()); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        seq = '{s_fetch(11'h020), s_fetch(11'h000), s_fetch(11'h007), s_fetch(11'h005)};
        foreach (seq[i]) begin
            apply(seq[i]);
            tick();
            n_cmp++;
            if (got_a() !== want_a()) begin n_bad++; $display("FAIL reset_retain_a[%0d]: got %h expected %h", i, got_a(), want_a()); end
            n_cmp++;
            if (got_b() !== want_b()) begin n_bad++; $display("FAIL reset_retain_b[%0d]: got %h expected %h", i, got_b(), want_b()); end
        end
    endtask

    task automatic test_random();
        stim_t s;
        for (int i = 0; i < 600; i++) begin
            s      = '0;
            s.req  = ($urandom_range(0, 3) != 0);
            s.addr = ($urandom_range(0, 1) == 0) ? 11'($urandom) : 11'(995 + $urandom_range(0, 10));
            s.ks   = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 2))
                0:       s.kd = 8'h55;
                1:       s.kd = 8'hAA;
                default: s.kd = 8'($urandom);
            endcase
            s.we   = ($urandom_range(0, 1) == 0);
            s.pa   = ($urandom_range(0, 1) == 0) ? 11'($urandom) : 11'(995 + $urandom_range(0, 10));
            s.pd   = 14'($urandom);
            s.ex   = ($urandom_range(0, 7) == 0);
            apply(s);
            tick();
            n_cmp++;
            if (got_a() !== want_a()) begin n_bad++; $display("FAIL random_a[%0d]: got %h expected %h", i, got_a(), want_a()); end
            n_cmp++;
            if (got_b() !== want_b()) begin n_bad++; $display("FAIL random_b[%0d]: got %h expected %h", i, got_b(), want_b()); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH_A; i++) mem_a[i] = NOP_A;
        for (int i = 0; i < DEPTH_B; i++) mem_b[i] = NOP_B;
        model_reset();
        apply(s_idle());
        test_reset();
        test_default_fetch();
        test_program();
        test_bad_key();
        test_out_of_range();
        test_prog_fetch_block();
        test_reset_in_prog();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 14, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 11, fetch/program address width.
REQ-003 SHALL have parameter DEPTH, default 2048, implemented words; legal range 1..2**ADDR_W.
REQ-004 SHALL have parameter NOP_WORD, default 0, word returned for out-of-range fetches.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port fetch_req  in  1  fetch request, sampled each cycle.
REQ-008 SHALL have port fetch_addr  in  ADDR_W  fetch word address.
REQ-009 SHALL have port fetch_valid  out  1  fetch_data holds the result of the previous cycle's accepted request.
REQ-010 SHALL have port fetch_data  out  DATA_W  registered instruction word.
REQ-011 SHALL have port fetch_err  out  1  previous accepted fetch had fetch_addr >= DEPTH.
REQ-012 SHALL have port key_strobe  in  1  unlock key byte valid.
REQ-013 SHALL have port key_data  in  8  unlock key byte.
REQ-014 SHALL have port prog_we  in  1  program-write strobe.
REQ-015 SHALL have port prog_addr  in  ADDR_W  program-write address.
REQ-016 SHALL have port prog_wdata  in  DATA_W  program-write word.
REQ-017 SHALL have port prog_exit  in  1  leave programming mode.
REQ-018 SHALL have port prog_mode  out  1  high while in state PROG.

Function
REQ-019 SHALL implement DEPTH x DATA_W storage; initial content all NOP_WORD; contents not altered by reset.
REQ-020 SHALL implement mode FSM with states RUN, KEY1, PROG; prog_mode = (state == PROG).
REQ-021 RUN -> KEY1 when key_strobe and key_data == 8'h55; otherwise stay RUN.
REQ-022 KEY1 -> PROG when key_strobe and key_data == 8'hAA in the cycle immediately after entering KEY1; any other cycle content (no strobe, or a wrong byte) -> RUN.
REQ-023 PROG -> RUN when prog_exit; key_strobe ignored in PROG.
REQ-024 Fetch accepted only in RUN or KEY1 with fetch_req high; accepted fetch -> next cycle fetch_valid=1, fetch_data=mem[fetch_addr] or NOP_WORD if out of range, fetch_err=(fetch_addr>=DEPTH).
REQ-025 Latency: exactly 1 cycle, one result per cycle, back-to-back requests supported.
REQ-026 No accepted fetch -> fetch_valid=0, fetch_err=0, fetch_data holds last value.
REQ-027 In PROG, fetch_req ignored (fetch_valid=0).
REQ-028 Write performed only in PROG with prog_we high and prog_addr < DEPTH; prog_we with prog_addr >= DEPTH is dropped silently.
REQ-029 prog_we in RUN or KEY1 ignored; memory unchanged.
REQ-030 Same cycle prog_we and prog_exit in PROG: write performed, then state RUN.
REQ-031 Written word visible to the first fetch accepted after return to RUN.
REQ-032 Addresses compared at full ADDR_W width, no wrap-around/modulo aliasing.

Reset
REQ-033 On rst_n low, asynchronously: state=RUN, fetch_valid=0, fetch_err=0, fetch_data=NOP_WORD, prog_mode=0.
REQ-034 Reset asserted in KEY1 or PROG returns to RUN; a write in progress on the same edge is not performed; earlier writes are retained.
REQ-035 No fetch accepted on the first clock edge while rst_n is low; normal operation from the first rising edge after rst_n high.

Verification
REQ-036 Defaults, reset, fetch_req=1 with addr 0..7 on consecutive cycles -> fetch_valid=1 each following cycle, fetch_data=0 throughout.
REQ-037 Key 55,AA -> prog_mode=1; write 0x3044@0x000, 0x3E07@0x007; prog_exit; fetch 0x007 -> 0x3E07 after 1 cycle, err=0.
REQ-038 Key 55, idle cycle, AA -> prog_mode stays 0; subsequent prog_we 0x1234@0x010 ignored; fetch 0x010 -> 0x0000.
REQ-039 DEPTH=1000: fetch 0x3E8 -> fetch_data=NOP_WORD, fetch_err=1; in PROG write to 0x3E8 dropped, fetch 0x3E7 unaffected.
REQ-040 In PROG, drive rst_n low mid-cycle -> prog_mode, fetch_valid drop immediately; after release, earlier written words read back intact.
REQ-041 In PROG, fetch_req=1 -> fetch_valid=0; same-cycle prog_we+prog_exit (0x2ABC@0x005) -> next cycle RUN, fetch 0x005 returns 0x2ABC.
